pipeline_hazard_ctrl: RTL and testbench

//  Stage-enable/flush sequencer for the 5-stage rv32i pipeline; pairs with the EX-stage forwarding unit.

---
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stage-enable / flush sequencer for the 5-stage rv32i pipeline.
// Handles load-use, imem/dmem waits and redirects that race an outstanding fetch.
module pipeline_hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_req,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   input  logic             id_ex_is_load,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic [REG_W-1:0] if_id_rs1,
   input  logic [REG_W-1:0] if_id_rs2,
   input  logic             if_id_uses_rs2,
   input  logic             br_taken,
   output logic             pc_load,
   output logic             pc_sel_redirect,
   output logic             redir_capture,
   output logic             if_id_load,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             back_load,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      REDIR_WAIT  = 2'd1,
      REDIR_ISSUE = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   dbusy, ibusy, lu;

   assign dbusy = dmem_req & ~dmem_resp;
   assign ibusy = imem_req & ~imem_resp;
   assign lu    = id_ex_is_load && (id_ex_rd != '0) &&
                  ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

   always_comb begin
      pc_load         = 1'b0;
      pc_sel_redirect = 1'b0;
      redir_capture   = 1'b0;
      if_id_load      = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_bubble    = 1'b0;
      back_load       = 1'b0;
      state_nxt       = state;
      if (rst) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (dbusy) begin
         // Whole pipe frozen; EX holds so a br_taken here will be presented again.
         if (state == REDIR_WAIT && imem_resp)
            state_nxt = REDIR_ISSUE;
      end else begin
         case (state)
            RUN: begin
               if (br_taken && !ibusy) begin
                  pc_load      = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  back_load    = 1'b1;
               end else if (br_taken) begin
                  // Fetch in flight on the wrong path: park the target, drop the response later.
                  redir_capture = 1'b1;
                  if_id_flush   = 1'b1;
                  id_ex_bubble  = 1'b1;
                  back_load     = 1'b1;
                  state_nxt     = REDIR_WAIT;
               end else if (ibusy || lu) begin
                  id_ex_bubble = 1'b1;
                  back_load    = 1'b1;
               end else begin
                  pc_load    = 1'b1;
                  if_id_load = 1'b1;
                  back_load  = 1'b1;
               end
            end
            REDIR_WAIT: begin
               id_ex_bubble = 1'b1;
               back_load    = 1'b1;
               if (imem_resp) begin
                  if_id_flush     = 1'b1;
                  pc_load         = 1'b1;
                  pc_sel_redirect = 1'b1;
                  state_nxt       = RUN;
               end
            end
            REDIR_ISSUE: begin
               pc_load         = 1'b1;
               pc_sel_redirect = 1'b1;
               if_id_flush     = 1'b1;
               id_ex_bubble    = 1'b1;
               back_load       = 1'b1;
               state_nxt       = RUN;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= '0;
      else if (!pc_load && (stall_cycles != '1))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue scoreboard of expected output vectors.
module tb_pipeline_hazard_ctrl;
   localparam int REG_W = 5;
   localparam int CNT_W = 4;

   // {pc_load, pc_sel_redirect, redir_capture, if_id_load, if_id_flush, id_ex_bubble, back_load}
   localparam logic [6:0] V_RESET = 7'b0000110;
   localparam logic [6:0] V_ALL   = 7'b1001001;
   localparam logic [6:0] V_HOLD  = 7'b0000000;
   localparam logic [6:0] V_STALL = 7'b0000011;
   localparam logic [6:0] V_NRED  = 7'b1000111;
   localparam logic [6:0] V_CAPT  = 7'b0010111;
   localparam logic [6:0] V_RFIRE = 7'b1100111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic imem_req = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
   logic id_ex_is_load = 0, if_id_uses_rs2 = 0, br_taken = 0;
   logic [REG_W-1:0] id_ex_rd = '0, if_id_rs1 = '0, if_id_rs2 = '0;
   logic pc_load, pc_sel_redirect, redir_capture, if_id_load, if_id_flush, id_ex_bubble, back_load;
   logic [CNT_W-1:0] stall_cycles;
   logic [6:0] outs;

   typedef struct {
      string      tag;
      logic [6:0] vec;
   } exp_t;
   exp_t sb[$];

   int checks = 0, passes = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_resp(imem_resp),
      .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .id_ex_is_load(id_ex_is_load), .id_ex_rd(id_ex_rd),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
      .br_taken(br_taken),
      .pc_load(pc_load), .pc_sel_redirect(pc_sel_redirect), .redir_capture(redir_capture),
      .if_id_load(if_id_load), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .back_load(back_load), .stall_cycles(stall_cycles)
   );

   assign outs = {pc_load, pc_sel_redirect, redir_capture, if_id_load, if_id_flush, id_ex_bubble, back_load};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   // Drive one cycle of inputs, sample combinational outputs at the negedge.
   task automatic step(input string tag, input logic ireq, input logic iresp, input logic dreq,
                       input logic dresp, input logic ld, input logic [REG_W-1:0] rd,
                       input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                       input logic u2, input logic br, input logic [6:0] exp);
      exp_t e;
      imem_req = ireq; imem_resp = iresp; dmem_req = dreq; dmem_resp = dresp;
      id_ex_is_load = ld; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
      if_id_uses_rs2 = u2; br_taken = br;
      sb.push_back('{tag, exp});
      @(negedge clk);
      e = sb.pop_front();
      check(e.tag, 32'(outs), 32'(e.vec));
      check({e.tag, "_cnt"}, 32'(stall_cycles), 32'(exp_cnt));
      if (!e.vec[6] && exp_cnt != (2**CNT_W) - 1) exp_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic idle(input string tag, input logic [6:0] exp);
      step(tag, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, exp);
   endtask

   initial begin
      @(negedge clk);
      check("reset_outs", 32'(outs), 32'(V_RESET));
      check("reset_cnt", 32'(stall_cycles), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      idle("run_idle", V_ALL);
      // load-use: lw x5 then add x6,x5,x1
      step("lu_rs1",     0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0, V_STALL);
      step("lu_after",   0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd1, 1, 0, V_ALL);
      step("lu_rs2",     0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, V_STALL);
      step("lu_x0",      0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, V_ALL);
      step("lu_rs2_unused", 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 0, V_ALL);
      // dmem wait: 3 busy cycles then response; br_taken ignored while frozen
      step("dbusy_1",    0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_HOLD);
      step("dbusy_br",   0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, V_HOLD);
      step("dbusy_lu",   0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, V_HOLD);
      step("dmem_resp",  0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_ALL);
      // imem wait
      step("ibusy_1",    1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_STALL);
      step("ibusy_2",    1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_STALL);
      step("ibusy_3",    1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_STALL);
      step("imem_resp",  1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_ALL);
      step("br_normal",  0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, V_NRED);
      // redirect racing an outstanding fetch
      step("br_capture", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, V_CAPT);
      step("rwait_1",    1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_STALL);
      step("rwait_2",    1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0, V_STALL);
      step("rwait_fire", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_RFIRE);
      idle("run_again", V_ALL);
      // fetch returns while dmem busy -> REDIR_ISSUE
      step("br_capture2", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, V_CAPT);
      step("rwait_3",    1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_STALL);
      step("resp_dbusy", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_HOLD);
      step("issue_hold", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_HOLD);
      step("issue_fire", 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_RFIRE);
      idle("run_again2", V_ALL);
      // reset pulsed in REDIR_WAIT discards the pending redirect
      step("br_capture3", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, V_CAPT);
      step("rwait_4",    1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_STALL);
      check("sat_cnt", 32'(stall_cycles), 32'((2**CNT_W) - 1));
      rst = 1'b1;
      #1;
      check("midrst_outs", 32'(outs), 32'(V_RESET));
      check("midrst_cnt", 32'(stall_cycles), 32'd0);
      exp_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      step("post_rst_resp", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, V_ALL);
      idle("post_rst_idle", V_ALL);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
